// File: rtl/hilo_div_ctrl_pkg.sv
// hilo_div_ctrl_pkg
//   Shared definitions for the HI/LO divide controller: FSM state encoding,
//   the nominal iteration count for 32-bit operands, and the EX-stage funct
//   codes that the decoder uses to derive start / is_signed.
package hilo_div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int DIV_CYCLES = 32;

    localparam logic [5:0] EXE_DIV  = 6'b011010;
    localparam logic [5:0] EXE_DIVU = 6'b011011;

    // Decoder helper: funct selects one of the two divide instructions.
    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == EXE_DIV) || (funct == EXE_DIVU);
    endfunction

endpackage

// File: rtl/hilo_div_ctrl_div_step.sv
// div_step
//   One combinational restoring-division iteration on the {rem, quo} pair.
//   The pair is shifted left by one; the divisor is trial-subtracted from the
//   upper half and, when the result is non-negative, the difference is kept
//   and a 1 is shifted into the quotient.
// Ports:
//   rem_i / quo_i   current partial remainder / quotient-dividend register
//   divisor_i       unsigned divisor magnitude
//   rem_o / quo_o   values after this iteration
module div_step
    import hilo_div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    // One extra bit so the bit shifted out of rem is not lost before the
    // trial subtraction; rem < divisor always holds, so DATA_W+1 bits suffice.
    logic [DATA_W:0] rem_sh;
    logic [DATA_W:0] diff;

    always_comb begin
        rem_sh = {rem_i, quo_i[DATA_W-1]};
        diff   = rem_sh - {1'b0, divisor_i};
        if (!diff[DATA_W]) begin
            rem_o = diff[DATA_W-1:0];
            quo_o = {quo_i[DATA_W-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[DATA_W-1:0];
            quo_o = {quo_i[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
//   Multi-cycle DIV/DIVU sequencer for the HI/LO pair in EX. Holds the
//   pipeline while iterating and writes quotient (LO) / remainder (HI) with a
//   single strobe.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   DIV_IDLE | waiting for start; nothing in flight
//   DIV_RUN  | one restoring step per cycle, DATA_W steps total
//   DIV_DONE | results valid on hi_o/lo_o, hilo_we_o high for this cycle
//
// Ports:
//   clk, resetn      clock, async active-low reset
//   start, is_signed divide present in EX; 1 = DIV, 0 = DIVU
//   opa, opb         dividend (rs), divisor (rt)
//   flush            cancel in-flight divide
//   stall_o          hold IF/ID/EX (combinational)
//   busy_o           FSM outside IDLE
//   hilo_we_o        one-cycle HI/LO write strobe
//   hi_o, lo_o       registered remainder / quotient
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic              flush,
    output logic              stall_o,
    output logic              busy_o,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic              we_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic [DATA_W-1:0] rem_d;
    logic [DATA_W-1:0] quo_d;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic              launch;
    logic              last_step;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    // Magnitudes are taken modulo 2^DATA_W: |0x80..0| stays 0x80..0, which
    // is the correct unsigned magnitude, so the most-negative case needs no
    // special handling anywhere downstream.
    always_comb begin
        abs_a     = (is_signed && opa[DATA_W-1]) ? (~opa + 1'b1) : opa;
        abs_b     = (is_signed && opb[DATA_W-1]) ? (~opb + 1'b1) : opb;
        launch    = start && !flush;
        last_step = (cnt_q == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            we_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    we_q <= 1'b0;
                    if (launch) begin
                        if (opb == '0) begin
                            state_q <= DIV_DONE;
                            lo_q    <= '1;
                            hi_q    <= opa;
                            we_q    <= 1'b1;
                        end else begin
                            state_q <= DIV_RUN;
                            cnt_q   <= '0;
                            rem_q   <= '0;
                            quo_q   <= abs_a;
                            dvs_q   <= abs_b;
                            q_neg_q <= is_signed && (opa[DATA_W-1] ^ opb[DATA_W-1]);
                            r_neg_q <= is_signed && opa[DATA_W-1];
                        end
                    end
                end
                DIV_RUN: begin
                    if (flush) begin
                        state_q <= DIV_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        // Sign fix is folded into the final step so the
                        // corrected results are already registered in DONE.
                        if (last_step) begin
                            state_q <= DIV_DONE;
                            cnt_q   <= '0;
                            lo_q    <= q_neg_q ? (~quo_d + 1'b1) : quo_d;
                            hi_q    <= r_neg_q ? (~rem_d + 1'b1) : rem_d;
                            we_q    <= 1'b1;
                        end
                    end
                end
                DIV_DONE: begin
                    state_q <= DIV_IDLE;
                    we_q    <= 1'b0;
                end
                default: begin
                    state_q <= DIV_IDLE;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    // A flush landing in the DONE cycle must still suppress the write.
    assign hilo_we_o = we_q && !flush;
    assign busy_o    = (state_q != DIV_IDLE);
    assign stall_o   = ((state_q == DIV_IDLE) && launch) || (state_q == DIV_RUN);
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule
